leaky_relu_derivative_lanes: RTL and testbench

// - Parametrised, multi-lane successor of the single-lane leaky-ReLU derivative unit in the backprop path.
// - Per lane: gradient dout = d when H>=0, else a mode-dependent value:
//   d*leak for leaky ReLU, 0 for ReLU, d for identity.
// - Adds a rounded and saturating multiply, a 2-stage pipeline and valid/ready backpressure.
// - Sits between the systolic-array gradient output and the unified buffer writeback.

---
 rtl/tpu_act_pkg.sv | 13 +
 rtl/fxp_mul_rnd_sat.sv | 42 ++++
 rtl/leaky_relu_derivative_lanes.sv | 111 +++++++++++
 tb/tb_leaky_relu_derivative_lanes.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tpu_act_pkg.sv
// Shared types and Q-format defaults for the activation-derivative datapath.
package tpu_act_pkg;
  typedef enum logic [1:0] {
    ACT_LEAKY = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_IDENT = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_e;

  localparam int ACT_LANES = 4;
  localparam int ACT_W     = 16;
  localparam int ACT_FRAC  = 8;
endpackage

// File: rtl/fxp_mul_rnd_sat.sv
// Signed fixed-point multiply (prod) plus round-half-up and saturate of a
// previously registered product (p -> out, sat).
module fxp_mul_rnd_sat #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0]   ina,
  input  logic signed [W-1:0]   inb,
  input  logic signed [2*W-1:0] p,
  output logic signed [2*W-1:0] prod,
  output logic signed [W-1:0]   out,
  output logic                  sat
);
  localparam int RW = 2*W + 1;
  localparam logic [RW-1:0]        HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [RW-1:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] a_x, b_x;
  logic signed [RW-1:0]  p_x, p_rnd, r;

  assign a_x  = {{W{ina[W-1]}}, ina};
  assign b_x  = {{W{inb[W-1]}}, inb};
  assign prod = a_x * b_x;

  // One extra bit of headroom so adding the rounding half can never wrap.
  assign p_x   = {p[2*W-1], p};
  assign p_rnd = p_x + HALF;
  assign r     = p_rnd >>> FRAC;

  always_comb begin
    out = r[W-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      out = MAXV[W-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      out = MINV[W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/leaky_relu_derivative_lanes.sv
// Multi-lane leaky-ReLU derivative: 2-stage valid/ready pipeline, per-lane
// rounded/saturating d*leak selected by H sign and per-beat mode.
module leaky_relu_derivative_lanes
  import tpu_act_pkg::*;
#(
  parameter int LANES = ACT_LANES,
  parameter int W     = ACT_W,
  parameter int FRAC  = ACT_FRAC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [W-1:0]         in_leak,
  input  logic [LANES*W-1:0]   in_d,
  input  logic [LANES*W-1:0]   in_h,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_d,
  output logic [LANES-1:0]     out_sat
);
  logic [LANES-1:0][W-1:0]   d_in, h_in;
  logic [2:1]                vld_pipe_q;
  logic                      adv2;

  logic [LANES-1:0][W-1:0]   s1_d_q;
  logic [LANES-1:0][2*W-1:0] s1_p_q;
  logic [LANES-1:0]          s1_hpos_q;
  act_mode_e                 s1_mode_q;

  logic [LANES-1:0][W-1:0]   s2_d_q;
  logic [LANES-1:0]          s2_sat_q;

  logic [LANES-1:0][2*W-1:0] prod;
  logic [LANES-1:0][W-1:0]   res_d;
  logic [LANES-1:0]          res_sat;
  logic [LANES-1:0]          hpos_in;

  assign d_in = in_d;
  assign h_in = in_h;

  // S2 can take a beat when empty or draining; S1 when empty or moving on.
  assign adv2      = !vld_pipe_q[2] || out_ready;
  assign in_ready  = !vld_pipe_q[1] || adv2;
  assign out_valid = vld_pipe_q[2];
  assign out_d     = s2_d_q;
  assign out_sat   = s2_sat_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [W-1:0] rs_out;
    logic                rs_sat;
    logic [W-1:0]        sel_d;
    logic                sel_sat;

    assign hpos_in[g] = !h_in[g][W-1];

    fxp_mul_rnd_sat #(.W(W), .FRAC(FRAC)) u_mul (
      .ina  (d_in[g]),
      .inb  (in_leak),
      .p    (s1_p_q[g]),
      .prod (prod[g]),
      .out  (rs_out),
      .sat  (rs_sat)
    );

    always_comb begin
      sel_d   = s1_d_q[g];
      sel_sat = 1'b0;
      if (!s1_hpos_q[g]) begin
        case (s1_mode_q)
          ACT_RELU:  sel_d = '0;
          ACT_IDENT: sel_d = s1_d_q[g];
          default: begin
            sel_d   = rs_out;
            sel_sat = rs_sat;
          end
        endcase
      end
    end

    assign res_d[g]   = sel_d;
    assign res_sat[g] = sel_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_d_q     <= '0;
      s1_p_q     <= '0;
      s1_hpos_q  <= '0;
      s1_mode_q  <= ACT_LEAKY;
      s2_d_q     <= '0;
      s2_sat_q   <= '0;
    end else begin
      if (adv2) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        s2_d_q        <= vld_pipe_q[1] ? res_d   : '0;
        s2_sat_q      <= vld_pipe_q[1] ? res_sat : '0;
      end
      // An idle accept slot clears S1 so empty stages always hold zeros.
      if (in_ready) begin
        vld_pipe_q[1] <= in_valid;
        s1_d_q        <= in_valid ? d_in    : '0;
        s1_p_q        <= in_valid ? prod    : '0;
        s1_hpos_q     <= in_valid ? hpos_in : '0;
        s1_mode_q     <= in_valid ? act_mode_e'(in_mode) : ACT_LEAKY;
      end
    end
  end
endmodule

// File: tb/tb_leaky_relu_derivative_lanes.sv
// Directed bench: hand-computed Q8.8 vectors through latency, backpressure,
// saturation, mode mixing and mid-stream reset.
module tb_leaky_relu_derivative_lanes;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_leak;
  logic [63:0] in_d, in_h, out_d;
  logic [3:0]  out_sat;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  vm[8];
  logic [15:0] vl[8];
  logic [63:0] vd[8], vh[8], ve[8];
  logic [3:0]  vs[8];

  leaky_relu_derivative_lanes #(.LANES(4), .W(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_leak(in_leak), .in_d(in_d), .in_h(in_h),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int k);
    in_mode = vm[k];
    in_leak = vl[k];
    in_d    = vd[k];
    in_h    = vh[k];
  endtask

  initial begin
    // lanes packed {lane3, lane2, lane1, lane0}
    vm[0] = 2'd0; vl[0] = 16'h0019;
    vd[0] = {16'hFF00, 16'h0100, 16'h8123, 16'h0200};
    vh[0] = {16'hFFFF, 16'hFFFF, 16'h0000, 16'hFF00};
    ve[0] = {16'hFFE7, 16'h0019, 16'h8123, 16'h0032}; vs[0] = 4'b0000;
    vm[1] = 2'd1; vl[1] = 16'h0019;
    vd[1] = {16'h7FFF, 16'h1234, 16'h0200, 16'h8123};
    vh[1] = {16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
    ve[1] = {16'h0000, 16'h1234, 16'h0000, 16'h8123}; vs[1] = 4'b0000;
    vm[2] = 2'd2; vl[2] = 16'h7FFF;
    vd[2] = {16'h7FFF, 16'hABCD, 16'h0200, 16'h8123};
    vh[2] = {16'h0100, 16'h8000, 16'hFFFF, 16'h0000};
    ve[2] = {16'h7FFF, 16'hABCD, 16'h0200, 16'h8123}; vs[2] = 4'b0000;
    vm[3] = 2'd0; vl[3] = 16'h7FFF;
    vd[3] = {16'h0000, 16'h0100, 16'h8000, 16'h7FFF};
    vh[3] = {16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    ve[3] = {16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF}; vs[3] = 4'b0011;
    vm[4] = 2'd3; vl[4] = 16'h0080;
    vd[4] = {16'h0200, 16'h0003, 16'hFFFF, 16'h0001};
    vh[4] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    ve[4] = {16'h0100, 16'h0002, 16'h0000, 16'h0001}; vs[4] = 4'b0000;
    vm[5] = 2'd0; vl[5] = 16'hFFFF;
    vd[5] = {16'h0000, 16'h8000, 16'hFF80, 16'h0080};
    vh[5] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    ve[5] = {16'h0000, 16'h0080, 16'h0001, 16'h0000}; vs[5] = 4'b0000;
    vm[6] = 2'd0; vl[6] = 16'h8000;
    vd[6] = {16'hFFFF, 16'h7FFF, 16'h0100, 16'h8000};
    vh[6] = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    ve[6] = {16'h0080, 16'h8000, 16'h8000, 16'h7FFF}; vs[6] = 4'b0101;
    vm[7] = 2'd1; vl[7] = 16'h1234;
    vd[7] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    vh[7] = {16'h8001, 16'h7FFF, 16'hFFFF, 16'h0000};
    ve[7] = {16'h0000, 16'h0003, 16'h0000, 16'h0001}; vs[7] = 4'b0000;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; apply(0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_d",     out_d,          64'd0);
    chk("rst_out_sat",   64'(out_sat),   64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // single beat: 2-cycle latency, then the stage empties back to zero
    apply(0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_c1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_c2_valid", 64'(out_valid), 64'd1);
    chk("lat_c2_d",     out_d,          ve[0]);
    chk("lat_c2_sat",   64'(out_sat),   64'(vs[0]));
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_d",     out_d,          64'd0);

    // 8 back-to-back beats, out_ready low on loop cycles 3..6
    begin
      int sent = 0, rcv = 0, infl = 0;
      logic stalled = 1'b0;
      logic [63:0] hold_d = '0;
      logic [3:0]  hold_s = '0;
      for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
        out_ready = !(cyc >= 3 && cyc <= 6);
        in_valid  = (sent < 8);
        if (sent < 8) apply(sent);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(!(infl == 2 && !out_ready)));
        if (stalled) begin
          chk("bp_hold_valid", 64'(out_valid), 64'd1);
          chk("bp_hold_d",     out_d,          hold_d);
          chk("bp_hold_sat",   64'(out_sat),   64'(hold_s));
        end
        if (out_valid && out_ready) begin
          chk($sformatf("bp_d%0d", rcv),   out_d,        ve[rcv]);
          chk($sformatf("bp_s%0d", rcv),   64'(out_sat), 64'(vs[rcv]));
          rcv++; infl--;
        end
        if (in_valid && in_ready) begin
          sent++; infl++;
        end
        stalled = out_valid && !out_ready;
        hold_d  = out_d;
        hold_s  = out_sat;
        tick();
      end
      in_valid = 1'b0;
      chk("bp_all_received", 64'(rcv), 64'd8);
    end
    out_ready = 1'b1;
    tick(); tick();

    // reset with two beats in flight
    out_ready = 1'b0;
    apply(1); in_valid = 1'b1; tick();
    apply(2); tick();
    in_valid = 1'b0;
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_d",     out_d,          64'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    apply(3); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_d",     out_d,          ve[3]);
    chk("post_rst_sat",   64'(out_sat),   64'(vs[3]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
